// File: rtl/ifid_hazard.sv
// ifid_hazard: IF/ID pipeline register merged with the load-use hazard detector.
// Captures the fetched PC+4 and instruction, slices out the register fields for
// decode, stalls fetch and IF/ID for one cycle on a load-use hazard, and flushes
// the captured instruction to NOP_INSTR on a taken branch.
// Optional build macro: IFID_PERF_CNT_EN adds saturating stall/flush counters;
// without it both counter ports are tied to zero.
module ifid_hazard #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] instr_i,
  input  logic        branch_taken_i,
  input  logic        idex_memread_i,
  input  logic [4:0]  idex_rt_i,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o,
  output logic [4:0]  rs_o,
  output logic [4:0]  rt_o,
  output logic [4:0]  rd_o,
  output logic        valid_o,
  output logic        stall_o,
  output logic        bubble_o,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
);

  logic hazard;

  assign rs_o = instr_o[25:21];
  assign rt_o = instr_o[20:16];
  assign rd_o = instr_o[15:11];

  // Load in EX writes a register the instruction in ID reads; $0 never counts.
  always_comb begin
    hazard = valid_o & idex_memread_i & (idex_rt_i != 5'd0) &
             ((idex_rt_i == rs_o) | (idex_rt_i == rt_o));
  end

  // A flush discards the instruction in ID, so its hazard must not stall fetch.
  assign stall_o  = hazard & ~branch_taken_i;
  assign bubble_o = stall_o;

  // IF/ID register: reset, then flush, then stall-hold, then normal capture.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_o    <= 32'd0;
      instr_o <= NOP_INSTR;
      valid_o <= 1'b0;
    end else if (branch_taken_i) begin
      instr_o <= NOP_INSTR;
      valid_o <= 1'b0;
    end else if (!stall_o) begin
      pc_o    <= pc_i;
      instr_o <= instr_i;
      valid_o <= 1'b1;
    end
  end

`ifdef IFID_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  // Saturating event counters; they stick at all-ones rather than wrapping.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      if (stall_o && (stall_cnt_q != 32'hFFFF_FFFF))
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (branch_taken_i && (flush_cnt_q != 32'hFFFF_FFFF))
        flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  assign stall_cnt_o = 32'd0;
  assign flush_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_ifid_hazard.sv
module tb_ifid_hazard;

  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam logic [31:0] ADD = 32'h0122_5020;  // add $10,$9,$2 : rs=9 rt=2 rd=10
  localparam logic [31:0] LW  = 32'h8d2a_0004;  // rs=9 rt=10

`ifdef IFID_PERF_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] pc_i, instr_i;
  logic        branch_taken_i, idex_memread_i;
  logic [4:0]  idex_rt_i;
  logic [31:0] pc_o, instr_o;
  logic [4:0]  rs_o, rt_o, rd_o;
  logic        valid_o, stall_o, bubble_o;
  logic [31:0] stall_cnt_o, flush_cnt_o;

  int checks = 0;
  int failures = 0;

  // reference model state
  logic [31:0] m_pc, m_instr;
  logic        m_valid;
  longint      m_scnt, m_fcnt;

  ifid_hazard #(.NOP_INSTR(NOP)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .pc_i(pc_i), .instr_i(instr_i),
    .branch_taken_i(branch_taken_i), .idex_memread_i(idex_memread_i),
    .idex_rt_i(idex_rt_i), .pc_o(pc_o), .instr_o(instr_o), .rs_o(rs_o),
    .rt_o(rt_o), .rd_o(rd_o), .valid_o(valid_o), .stall_o(stall_o),
    .bubble_o(bubble_o), .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit model_stall();
    logic [4:0] src1, src2;
    src1 = m_instr[25:21];
    src2 = m_instr[20:16];
    if (!m_valid || !idex_memread_i || idex_rt_i == 0 || branch_taken_i) return 1'b0;
    return (idex_rt_i == src1) || (idex_rt_i == src2);
  endfunction

  task automatic drive(input bit rst, input logic [31:0] pc, input logic [31:0] instr,
                       input bit br, input bit mr, input logic [4:0] rt);
    rst_i = rst; pc_i = pc; instr_i = instr;
    branch_taken_i = br; idex_memread_i = mr; idex_rt_i = rt;
  endtask

  // check combinational outputs, clock once, advance the model, check registers
  task automatic step();
    bit s;
    #1;
    s = model_stall();
    check("stall", {31'd0, stall_o}, {31'd0, s});
    check("bubble", {31'd0, bubble_o}, {31'd0, s});
    @(posedge clk_i);
    if (rst_i) begin
      m_pc = 0; m_instr = NOP; m_valid = 0; m_scnt = 0; m_fcnt = 0;
    end else begin
      if (s && m_scnt < 64'hFFFF_FFFF) m_scnt++;
      if (branch_taken_i && m_fcnt < 64'hFFFF_FFFF) m_fcnt++;
      if (branch_taken_i) begin
        m_instr = NOP; m_valid = 0;
      end else if (!s) begin
        m_pc = pc_i; m_instr = instr_i; m_valid = 1;
      end
    end
    #1;
    check("pc", pc_o, m_pc);
    check("instr", instr_o, m_instr);
    check("valid", {31'd0, valid_o}, {31'd0, m_valid});
    check("rs", {27'd0, rs_o}, {27'd0, m_instr[25:21]});
    check("rt", {27'd0, rt_o}, {27'd0, m_instr[20:16]});
    check("rd", {27'd0, rd_o}, {27'd0, m_instr[15:11]});
    check("stall_cnt", stall_cnt_o, CNT_EN ? m_scnt[31:0] : 32'd0);
    check("flush_cnt", flush_cnt_o, CNT_EN ? m_fcnt[31:0] : 32'd0);
  endtask

  typedef struct {
    bit          rst;
    logic [31:0] pc;
    logic [31:0] instr;
    bit          br;
    bit          mr;
    logic [4:0]  rt;
    bit          e_stall;   // before the edge
    logic [31:0] e_pc;      // after the edge
    logic [31:0] e_instr;
    bit          e_valid;
  } vec_t;

  vec_t vecs[13];

  initial begin
    m_pc = 0; m_instr = NOP; m_valid = 0; m_scnt = 0; m_fcnt = 0;
    vecs[0]  = '{1, 32'd0,  NOP, 0, 0, 5'd0,  0, 32'd0,  NOP, 0};
    vecs[1]  = '{1, 32'd0,  NOP, 0, 0, 5'd0,  0, 32'd0,  NOP, 0};
    vecs[2]  = '{0, 32'd4,  ADD, 0, 0, 5'd0,  0, 32'd4,  ADD, 1};
    vecs[3]  = '{0, 32'd8,  NOP, 0, 1, 5'd9,  1, 32'd4,  ADD, 1};  // load-use on rs
    vecs[4]  = '{0, 32'd8,  NOP, 0, 0, 5'd9,  0, 32'd8,  NOP, 1};
    vecs[5]  = '{0, 32'd12, ADD, 0, 1, 5'd0,  0, 32'd12, ADD, 1};  // rt=0 never hazards
    vecs[6]  = '{0, 32'd16, LW,  0, 0, 5'd2,  0, 32'd16, LW,  1};  // no memread
    vecs[7]  = '{0, 32'd20, ADD, 1, 1, 5'd10, 0, 32'd16, NOP, 0};  // flush beats stall
    vecs[8]  = '{0, 32'd20, ADD, 0, 0, 5'd0,  0, 32'd20, ADD, 1};
    vecs[9]  = '{1, 32'd24, LW,  0, 1, 5'd2,  1, 32'd0,  NOP, 0};  // reset mid-stall
    vecs[10] = '{0, 32'd24, ADD, 0, 1, 5'd2,  0, 32'd24, ADD, 1};
    vecs[11] = '{0, 32'd28, NOP, 0, 1, 5'd2,  1, 32'd24, ADD, 1};  // load-use on rt
    vecs[12] = '{0, 32'd28, NOP, 0, 0, 5'd2,  0, 32'd28, NOP, 1};

    drive(1, 0, NOP, 0, 0, 0);
    @(posedge clk_i); #1;

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].pc, vecs[i].instr, vecs[i].br, vecs[i].mr, vecs[i].rt);
      #1;
      check($sformatf("v%0d_stall", i), {31'd0, stall_o}, {31'd0, vecs[i].e_stall});
      step();
      check($sformatf("v%0d_pc", i), pc_o, vecs[i].e_pc);
      check($sformatf("v%0d_instr", i), instr_o, vecs[i].e_instr);
      check($sformatf("v%0d_valid", i), {31'd0, valid_o}, {31'd0, vecs[i].e_valid});
    end

    // counters: 3 stalls and 2 flushes after a reset
    drive(1, 0, NOP, 0, 0, 0); step();
    drive(0, 4, ADD, 0, 0, 0); step();
    for (int k = 0; k < 3; k++) begin
      drive(0, 8, ADD, 0, 1, 5'd9); step();
      drive(0, 8, ADD, 0, 0, 5'd9); step();
    end
    drive(0, 12, ADD, 1, 0, 0); step();
    drive(0, 12, ADD, 1, 0, 0); step();
    check("cnt_stall3", stall_cnt_o, CNT_EN ? 32'd3 : 32'd0);
    check("cnt_flush2", flush_cnt_o, CNT_EN ? 32'd2 : 32'd0);

    // randomized run against the model
    for (int n = 0; n < 400; n++) begin
      logic [31:0] ins;
      ins = $urandom;
      ins[25:21] = 5'($urandom_range(0, 3));
      ins[20:16] = 5'($urandom_range(0, 3));
      drive(($urandom_range(0, 31) == 0), $urandom, ins,
            ($urandom_range(0, 7) == 0), $urandom_range(0, 1) == 1,
            5'($urandom_range(0, 3)));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
